// File: rtl/ram_port_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module   : ram_port_arbiter_pkg
// Purpose  : Shared types and defaults for the single-port RAM arbiter:
//            FSM state encodings, owner encodings, default bus widths and
//            the streak-counter width helper.
// Revision : 1.0  initial release
// ============================================================================
package ram_port_arbiter_pkg;

    localparam int unsigned RAM_ADDR_W = 8;
    localparam int unsigned RAM_DATA_W = 8;

    // 2'b11 is never entered; the FSM treats it as IDLE
    typedef enum logic [1:0] {
        ARB_IDLE = 2'b00,
        ARB_ADDR = 2'b01,
        ARB_DATA = 2'b10
    } arb_state_e;

    typedef enum logic {
        ARB_OWNER_IF = 1'b0,
        ARB_OWNER_LS = 1'b1
    } arb_owner_e;

    // Bits needed to count 0..max_streak inclusive (at least one bit)
    function automatic int unsigned streak_width(input int unsigned max_streak);
        int unsigned w;
        w = $clog2(max_streak + 1);
        return (w == 0) ? 1 : w;
    endfunction

endpackage
`default_nettype wire

// File: rtl/ram_port_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module   : ram_port_arbiter_if
// Purpose  : Request/response bundle between the fetch and load/store
//            requesters, the RAM macro and the RAM port arbiter.
//            slave  = arbiter side, master = requester/RAM side.
// Revision : 1.0  initial release
// ============================================================================
interface ram_port_arbiter_if
    import ram_port_arbiter_pkg::*;
#(
    parameter int unsigned ADDR_W = RAM_ADDR_W,
    parameter int unsigned DATA_W = RAM_DATA_W
);
    // instruction fetch path
    logic              if_req;
    logic [ADDR_W-1:0] if_addr;
    logic              if_gnt;
    logic              if_rvalid;
    logic [DATA_W-1:0] if_rdata;
    // load/store path
    logic              ls_req;
    logic              ls_we;
    logic [ADDR_W-1:0] ls_addr;
    logic [DATA_W-1:0] ls_wdata;
    logic              ls_gnt;
    logic              ls_done;
    logic [DATA_W-1:0] ls_rdata;
    // RAM macro port
    logic              ram_en;
    logic              ram_we;
    logic [ADDR_W-1:0] ram_addr;
    logic [DATA_W-1:0] ram_wdata;
    logic [DATA_W-1:0] ram_rdata;
    // status
    logic              busy;

    modport slave (
        input  if_req, if_addr, ls_req, ls_we, ls_addr, ls_wdata, ram_rdata,
        output if_gnt, if_rvalid, if_rdata, ls_gnt, ls_done, ls_rdata,
               ram_en, ram_we, ram_addr, ram_wdata, busy
    );

    modport master (
        output if_req, if_addr, ls_req, ls_we, ls_addr, ls_wdata, ram_rdata,
        input  if_gnt, if_rvalid, if_rdata, ls_gnt, ls_done, ls_rdata,
               ram_en, ram_we, ram_addr, ram_wdata, busy
    );

endinterface
`default_nettype wire

// File: rtl/ram_arb_pick.sv
`default_nettype none
// ============================================================================
// Module   : ram_arb_pick
// Purpose  : Combinational winner selection between fetch and load/store.
//            Load/store wins unless fetch is pending and load/store has
//            already taken MAX_DATA_STREAK grants in a row while fetch waited.
// Revision : 1.0  initial release
// ============================================================================
module ram_arb_pick
    import ram_port_arbiter_pkg::*;
#(
    parameter int unsigned MAX_DATA_STREAK = 2,
    parameter int unsigned STREAK_W        = streak_width(MAX_DATA_STREAK)
) (
    input  logic                if_req,
    input  logic                ls_req,
    input  logic [STREAK_W-1:0] streak,
    output logic                grant_if,
    output logic                grant_ls,
    output logic [STREAK_W-1:0] streak_next
);

    logic w_at_limit;

    assign w_at_limit = (streak == STREAK_W'(MAX_DATA_STREAK));

    // Pick the winner and compute the streak left behind by this arbitration
    always_comb begin
        grant_if    = 1'b0;
        grant_ls    = 1'b0;
        streak_next = '0;
        if (ls_req && !(if_req && w_at_limit)) begin
            grant_ls = 1'b1;
        end else if (if_req) begin
            grant_if = 1'b1;
        end
        // streak only grows while fetch is being held off; anything else clears it
        if (if_req && grant_ls) begin
            streak_next = w_at_limit ? streak : streak + 1'b1;
        end
    end

endmodule
`default_nettype wire

// File: rtl/ram_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : ram_port_arbiter
// Purpose  : Shares one synchronous RAM port between instruction fetch and
//            load/store. Every access runs arbitrate -> address -> data;
//            arbitration also happens in the data cycle so accesses can run
//            back to back at one per two cycles.
// Revision : 1.0  initial release
// ============================================================================
module ram_port_arbiter
    import ram_port_arbiter_pkg::*;
#(
    parameter int unsigned ADDR_W          = RAM_ADDR_W,
    parameter int unsigned DATA_W          = RAM_DATA_W,
    parameter int unsigned MAX_DATA_STREAK = 2
) (
    input  logic                   clk,
    input  logic                   rst_n,
    ram_port_arbiter_if.slave      bus
);

    localparam int unsigned c_streak_w = streak_width(MAX_DATA_STREAK);

    arb_state_e              r_state;
    arb_owner_e              r_owner;
    logic                    r_we;
    logic [ADDR_W-1:0]       r_addr;
    logic [DATA_W-1:0]       r_wdata;
    logic [c_streak_w-1:0]   r_streak;

    logic                    w_grant_if;
    logic                    w_grant_ls;
    logic [c_streak_w-1:0]   w_streak_next;
    logic                    w_in_addr;
    logic                    w_in_data;
    logic                    w_own_if;
    logic                    w_own_ls;

    ram_arb_pick #(
        .MAX_DATA_STREAK (MAX_DATA_STREAK),
        .STREAK_W        (c_streak_w)
    ) u_pick (
        .if_req      (bus.if_req),
        .ls_req      (bus.ls_req),
        .streak      (r_streak),
        .grant_if    (w_grant_if),
        .grant_ls    (w_grant_ls),
        .streak_next (w_streak_next)
    );

    // FSM plus request latch: the winner's request is captured at arbitration,
    // so requests are never looked at during the address cycle
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= ARB_IDLE;
            r_owner  <= ARB_OWNER_IF;
            r_we     <= 1'b0;
            r_addr   <= '0;
            r_wdata  <= '0;
            r_streak <= '0;
        end else begin
            case (r_state)
                ARB_IDLE, ARB_DATA: begin
                    r_streak <= w_streak_next;
                    if (w_grant_ls) begin
                        r_owner <= ARB_OWNER_LS;
                        r_we    <= bus.ls_we;
                        r_addr  <= bus.ls_addr;
                        r_wdata <= bus.ls_wdata;
                        r_state <= ARB_ADDR;
                    end else if (w_grant_if) begin
                        r_owner <= ARB_OWNER_IF;
                        r_we    <= 1'b0;
                        r_addr  <= bus.if_addr;
                        r_wdata <= '0;
                        r_state <= ARB_ADDR;
                    end else begin
                        r_state <= ARB_IDLE;
                    end
                end
                ARB_ADDR: begin
                    r_state <= ARB_DATA;
                end
                default: begin
                    r_state <= ARB_IDLE;
                end
            endcase
        end
    end

    // Outputs are decoded from state and latched owner only, so no request
    // input reaches an output combinationally
    assign w_in_addr = (r_state == ARB_ADDR);
    assign w_in_data = (r_state == ARB_DATA);
    assign w_own_if  = (r_owner == ARB_OWNER_IF);
    assign w_own_ls  = (r_owner == ARB_OWNER_LS);

    assign bus.ram_en    = w_in_addr;
    assign bus.ram_we    = w_in_addr & r_we;
    assign bus.ram_addr  = w_in_addr ? r_addr : '0;
    assign bus.ram_wdata = (w_in_addr & r_we) ? r_wdata : '0;

    assign bus.if_gnt    = w_in_addr & w_own_if;
    assign bus.ls_gnt    = w_in_addr & w_own_ls;
    assign bus.if_rvalid = w_in_data & w_own_if;
    assign bus.ls_done   = w_in_data & w_own_ls;

    // RAM read data is only forwarded to the owner of a load/fetch data cycle
    assign bus.if_rdata  = (w_in_data & w_own_if) ? bus.ram_rdata : '0;
    assign bus.ls_rdata  = (w_in_data & w_own_ls & ~r_we) ? bus.ram_rdata : '0;

    assign bus.busy      = w_in_addr | w_in_data;

endmodule
`default_nettype wire

// File: tb/tb_ram_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_ram_port_arbiter
// Purpose  : Self-checking bench for ram_port_arbiter with a RAM macro model,
//            queue-driven requesters and a transaction-level reference model.
// Revision : 1.0  initial release
// ============================================================================
module tb_ram_port_arbiter;

    localparam int AW   = 8;
    localparam int DW   = 8;
    localparam int MAXS = 2;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    always #5 clk = ~clk;

    ram_port_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

    ram_port_arbiter #(
        .ADDR_W          (AW),
        .DATA_W          (DW),
        .MAX_DATA_STREAK (MAXS)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    // RAM macro: synchronous, read data valid the cycle after ram_en
    logic [DW-1:0] mem [256];
    always @(posedge clk) begin
        if (bus.ram_en) begin
            if (bus.ram_we) mem[bus.ram_addr] <= bus.ram_wdata;
            else            bus.ram_rdata     <= mem[bus.ram_addr];
        end
    end

    typedef struct packed {
        logic          is_ls;
        logic          we;
        logic [AW-1:0] addr;
        logic [DW-1:0] wdata;
    } acc_t;

    acc_t if_q[$];
    acc_t ls_q[$];
    bit   gaps, hold_extra, if_held, ls_held;
    logic [7:0] gl[$];
    int   cyc;
    int   n_pass, n_total;

    // Reference model: one access "in address phase", one "in data phase"
    logic [DW-1:0] ref_mem [256];
    bit   ma_v, md_v;
    acc_t ma, md;
    int   m_streak;
    logic e_if_gnt, e_ls_gnt, e_ram_en, e_ram_we, e_if_rvalid, e_ls_done, e_busy;
    logic [AW-1:0] e_ram_addr;
    logic [DW-1:0] e_ram_wdata, e_if_rdata, e_ls_rdata;

    function automatic acc_t rand_acc(input bit ls);
        acc_t a;
        a.is_ls = ls;
        a.we    = ls ? 1'($urandom_range(0, 1)) : 1'b0;
        a.addr  = 8'($urandom);
        a.wdata = a.we ? 8'($urandom) : 8'h00;
        return a;
    endfunction

    function automatic logic [38:0] dut_outs();
        return {bus.if_gnt, bus.if_rvalid, bus.if_rdata, bus.ls_gnt, bus.ls_done,
                bus.ls_rdata, bus.ram_en, bus.ram_we, bus.ram_addr, bus.ram_wdata, bus.busy};
    endfunction

    task automatic model_reset();
        ma_v = 1'b0; md_v = 1'b0; ma = '0; md = '0; m_streak = 0;
    endtask

    // Predict what the next clock edge produces from the requests now visible
    task automatic model_step();
        acc_t nxt;
        bit   nxt_v;
        nxt   = '0;
        nxt_v = 1'b0;
        if (!ma_v) begin
            if (bus.ls_req && !(bus.if_req && m_streak >= MAXS)) begin
                nxt.is_ls = 1'b1; nxt.we = bus.ls_we; nxt.addr = bus.ls_addr;
                nxt.wdata = bus.ls_wdata; nxt_v = 1'b1;
                m_streak  = bus.if_req ? ((m_streak < MAXS) ? m_streak + 1 : MAXS) : 0;
            end else if (bus.if_req) begin
                nxt.is_ls = 1'b0; nxt.we = 1'b0; nxt.addr = bus.if_addr;
                nxt.wdata = '0; nxt_v = 1'b1;
                m_streak  = 0;
            end else begin
                m_streak = 0;
            end
        end
        md_v = ma_v; md = ma; ma_v = nxt_v; ma = nxt;
        e_if_rvalid = md_v && !md.is_ls;
        e_ls_done   = md_v && md.is_ls;
        e_if_rdata  = e_if_rvalid ? ref_mem[md.addr] : '0;
        e_ls_rdata  = (e_ls_done && !md.we) ? ref_mem[md.addr] : '0;
        e_if_gnt    = ma_v && !ma.is_ls;
        e_ls_gnt    = ma_v && ma.is_ls;
        e_ram_en    = ma_v;
        e_ram_we    = ma_v && ma.we;
        e_ram_addr  = ma_v ? ma.addr : '0;
        e_ram_wdata = (ma_v && ma.we) ? ma.wdata : '0;
        e_busy      = ma_v || md_v;
        if (ma_v && ma.we) ref_mem[ma.addr] = ma.wdata;
    endtask

    // Requesters: drop (or replace) a request once granted, optionally one cycle late
    task automatic drive_agents();
        acc_t a;
        if (bus.if_req) begin
            if (bus.if_gnt && hold_extra && !if_held) if_held = 1'b1;
            else if (bus.if_gnt || if_held) begin if_held = 1'b0; bus.if_req = 1'b0; end
        end
        if (!bus.if_req && if_q.size() > 0 && (!gaps || $urandom_range(0, 2) == 0)) begin
            a = if_q.pop_front();
            bus.if_addr = a.addr;
            bus.if_req  = 1'b1;
        end
        if (bus.ls_req) begin
            if (bus.ls_gnt && hold_extra && !ls_held) ls_held = 1'b1;
            else if (bus.ls_gnt || ls_held) begin ls_held = 1'b0; bus.ls_req = 1'b0; end
        end
        if (!bus.ls_req && ls_q.size() > 0 && (!gaps || $urandom_range(0, 2) == 0)) begin
            a = ls_q.pop_front();
            bus.ls_we    = a.we;
            bus.ls_addr  = a.addr;
            bus.ls_wdata = a.wdata;
            bus.ls_req   = 1'b1;
        end
    endtask

    // One clock: model prediction, edge, sample 1 time unit later, react
    task automatic step();
        model_step();
        @(posedge clk);
        #1;
        cyc++;
        if (bus.if_gnt) gl.push_back(8'h49);
        if (bus.ls_gnt) gl.push_back(8'h4C);
        drive_agents();
    endtask

    function automatic bit pending();
        return (if_q.size() > 0) || (ls_q.size() > 0) || bus.if_req || bus.ls_req || bus.busy;
    endfunction

    task automatic test_reset();
        logic [DW-1:0] old;
        acc_t a;
        bit   seen;
        int   cnt;
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        n_total++; if (dut_outs() !== 39'd0) $display("FAIL reset_outs: got %h want 0", dut_outs()); else n_pass++;
        n_total++; if (bus.busy !== 1'b0) $display("FAIL reset_busy: got %b want 0", bus.busy); else n_pass++;
        @(negedge clk) rst_n = 1'b1;
        model_reset();
        old = ref_mem[8'h44];
        a.is_ls = 1'b1; a.we = 1'b1; a.addr = 8'h44; a.wdata = 8'h77;
        ls_q.push_back(a);
        seen = 1'b0;
        for (int i = 0; i < 8 && !seen; i++) begin
            step();
            if (bus.ls_gnt) seen = 1'b1;
        end
        n_total++; if (!seen) $display("FAIL reset_setup_gnt: got no ls_gnt want one within 8 cycles"); else n_pass++;
        n_total++; if (bus.ram_we !== 1'b1) $display("FAIL reset_setup_we: got %b want 1", bus.ram_we); else n_pass++;
        #2 rst_n = 1'b0;
        #1;
        n_total++; if (dut_outs() !== 39'd0) $display("FAIL reset_mid_outs: got %h want 0", dut_outs()); else n_pass++;
        n_total++; if (bus.busy !== 1'b0) $display("FAIL reset_mid_busy: got %b want 0", bus.busy); else n_pass++;
        // the address cycle was cut before its clock edge, so the RAM never saw the write
        model_reset();
        ref_mem[8'h44] = old;
        ls_q.delete();
        bus.ls_req = 1'b0;
        ls_held    = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        cnt = 0;
        repeat (4) begin
            step();
            cnt += int'(bus.ls_done) + int'(bus.ls_gnt);
        end
        n_total++; if (cnt !== 0) $display("FAIL reset_no_late_done: got %0d events want 0", cnt); else n_pass++;
    endtask

    task automatic test_fetch();
        mem[8'h10]     = 8'hA5;
        ref_mem[8'h10] = 8'hA5;
        bus.if_addr = 8'h10;
        bus.if_req  = 1'b1;
        step();
        n_total++; if ({bus.if_gnt, bus.ram_en, bus.ram_we, bus.ram_addr} !== {1'b1, 1'b1, 1'b0, 8'h10})
            $display("FAIL fetch_addr_cycle: got %b%b%b %h want 110 10", bus.if_gnt, bus.ram_en, bus.ram_we, bus.ram_addr);
        else n_pass++;
        step();
        n_total++; if ({bus.if_rvalid, bus.if_gnt, bus.if_rdata} !== {1'b1, 1'b0, 8'hA5})
            $display("FAIL fetch_data_cycle: got %b%b %h want 10 a5", bus.if_rvalid, bus.if_gnt, bus.if_rdata);
        else n_pass++;
        n_total++; if ({bus.if_rvalid, bus.if_rdata} !== {e_if_rvalid, e_if_rdata})
            $display("FAIL fetch_model: got %b %h want %b %h", bus.if_rvalid, bus.if_rdata, e_if_rvalid, e_if_rdata);
        else n_pass++;
        step();
        n_total++; if ({bus.busy, bus.if_rvalid} !== 2'b00)
            $display("FAIL fetch_idle: got busy %b rvalid %b want 0 0", bus.busy, bus.if_rvalid);
        else n_pass++;
    endtask

    task automatic test_store_load();
        acc_t a;
        int we_cnt, done_cnt, n;
        logic [DW-1:0] rd[$];
        a.is_ls = 1'b1; a.we = 1'b1; a.addr = 8'h20; a.wdata = 8'h3C;
        ls_q.push_back(a);
        a.we = 1'b0; a.wdata = 8'h00;
        ls_q.push_back(a);
        we_cnt = 0; done_cnt = 0; n = 0;
        while (pending() && n < 30) begin
            step();
            n++;
            we_cnt += int'(bus.ram_we);
            if (bus.ls_done) begin done_cnt++; rd.push_back(bus.ls_rdata); end
        end
        n_total++; if (n >= 30) $display("FAIL sl_timeout: got %0d cycles want < 30", n); else n_pass++;
        n_total++; if (we_cnt !== 1) $display("FAIL sl_we_count: got %0d want 1", we_cnt); else n_pass++;
        n_total++; if (done_cnt !== 2) $display("FAIL sl_done_count: got %0d want 2", done_cnt); else n_pass++;
        if (rd.size() == 2) begin
            n_total++; if (rd[0] !== 8'h00) $display("FAIL sl_store_rdata: got %h want 00", rd[0]); else n_pass++;
            n_total++; if (rd[1] !== 8'h3C) $display("FAIL sl_load_rdata: got %h want 3c", rd[1]); else n_pass++;
        end
    endtask

    task automatic test_priority();
        logic [47:0] got, want;
        int n;
        want = "LLILLI";
        gl.delete();
        repeat (2) if_q.push_back(rand_acc(1'b0));
        repeat (5) ls_q.push_back(rand_acc(1'b1));
        n = 0;
        while (pending() && n < 60) begin
            step();
            n++;
            n_total++; if ({bus.if_gnt, bus.ls_gnt} !== {e_if_gnt, e_ls_gnt})
                $display("FAIL prio_gnt: got if %b ls %b want if %b ls %b", bus.if_gnt, bus.ls_gnt, e_if_gnt, e_ls_gnt);
            else n_pass++;
        end
        n_total++; if (n >= 60) $display("FAIL prio_timeout: got %0d cycles want < 60", n); else n_pass++;
        got = '0;
        for (int i = 0; i < 6 && i < gl.size(); i++) got = {got[39:0], gl[i]};
        n_total++; if (got !== want) $display("FAIL prio_order: got %s want %s", got, want); else n_pass++;
    endtask

    task automatic test_back_to_back();
        int g[$];
        int n, idle_between;
        bit started;
        repeat (2) begin
            acc_t a;
            a = rand_acc(1'b1);
            a.we = 1'b0; a.wdata = '0;
            ls_q.push_back(a);
        end
        n = 0; idle_between = 0; started = 1'b0;
        while (pending() && n < 30) begin
            step();
            n++;
            if (bus.ls_gnt) begin g.push_back(cyc); started = 1'b1; end
            if (started && g.size() < 2 && !bus.busy) idle_between++;
            n_total++; if ({bus.busy, bus.ls_done, bus.ls_rdata} !== {e_busy, e_ls_done, e_ls_rdata})
                $display("FAIL b2b_model: got %b %b %h want %b %b %h", bus.busy, bus.ls_done, bus.ls_rdata, e_busy, e_ls_done, e_ls_rdata);
            else n_pass++;
        end
        n_total++; if (n >= 30) $display("FAIL b2b_timeout: got %0d cycles want < 30", n); else n_pass++;
        n_total++; if (g.size() !== 2) $display("FAIL b2b_gnt_count: got %0d want 2", g.size()); else n_pass++;
        if (g.size() == 2) begin
            n_total++; if (g[1] - g[0] !== 2) $display("FAIL b2b_spacing: got %0d want 2", g[1] - g[0]); else n_pass++;
        end
        n_total++; if (idle_between !== 0) $display("FAIL b2b_busy_gap: got %0d idle cycles want 0", idle_between); else n_pass++;
    endtask

    task automatic test_held_req();
        int n, if_g, ls_g;
        bit prev_g;
        hold_extra = 1'b1;
        if_q.push_back(rand_acc(1'b0));
        ls_q.push_back(rand_acc(1'b1));
        n = 0; if_g = 0; ls_g = 0; prev_g = 1'b0;
        while (pending() && n < 30) begin
            step();
            n++;
            if_g += int'(bus.if_gnt);
            ls_g += int'(bus.ls_gnt);
            n_total++; if ((prev_g && (bus.if_gnt || bus.ls_gnt)) !== 1'b0)
                $display("FAIL held_gnt_in_data: got gnt if %b ls %b want none", bus.if_gnt, bus.ls_gnt);
            else n_pass++;
            prev_g = bus.if_gnt | bus.ls_gnt;
        end
        hold_extra = 1'b0;
        n_total++; if (n >= 30) $display("FAIL held_timeout: got %0d cycles want < 30", n); else n_pass++;
        n_total++; if (if_g !== 1) $display("FAIL held_if_gnts: got %0d want 1", if_g); else n_pass++;
        n_total++; if (ls_g !== 1) $display("FAIL held_ls_gnts: got %0d want 1", ls_g); else n_pass++;
    endtask

    task automatic test_random();
        int n;
        gaps = 1'b1;
        repeat (30) if_q.push_back(rand_acc(1'b0));
        repeat (30) ls_q.push_back(rand_acc(1'b1));
        n = 0;
        while (pending() && n < 1500) begin
            step();
            n++;
            n_total++; if ({bus.if_gnt, bus.ls_gnt, bus.if_rvalid, bus.ls_done, bus.busy} !==
                           {e_if_gnt, e_ls_gnt, e_if_rvalid, e_ls_done, e_busy})
                $display("FAIL rnd_handshake: got %b%b%b%b%b want %b%b%b%b%b", bus.if_gnt, bus.ls_gnt, bus.if_rvalid,
                         bus.ls_done, bus.busy, e_if_gnt, e_ls_gnt, e_if_rvalid, e_ls_done, e_busy);
            else n_pass++;
            n_total++; if ({bus.ram_en, bus.ram_we, bus.ram_addr, bus.ram_wdata} !== {e_ram_en, e_ram_we, e_ram_addr, e_ram_wdata})
                $display("FAIL rnd_ram: got %b%b %h %h want %b%b %h %h", bus.ram_en, bus.ram_we, bus.ram_addr, bus.ram_wdata,
                         e_ram_en, e_ram_we, e_ram_addr, e_ram_wdata);
            else n_pass++;
            n_total++; if ({bus.if_rdata, bus.ls_rdata} !== {e_if_rdata, e_ls_rdata})
                $display("FAIL rnd_rdata: got if %h ls %h want if %h ls %h", bus.if_rdata, bus.ls_rdata, e_if_rdata, e_ls_rdata);
            else n_pass++;
        end
        gaps = 1'b0;
        n_total++; if (n >= 1500) $display("FAIL rnd_timeout: got %0d cycles want < 1500", n); else n_pass++;
    endtask

    initial begin
        n_pass = 0; n_total = 0; cyc = 0;
        gaps = 1'b0; hold_extra = 1'b0; if_held = 1'b0; ls_held = 1'b0;
        bus.if_req = 1'b0; bus.if_addr = '0;
        bus.ls_req = 1'b0; bus.ls_we = 1'b0; bus.ls_addr = '0; bus.ls_wdata = '0;
        for (int i = 0; i < 256; i++) begin
            mem[i]     = 8'($urandom);
            ref_mem[i] = mem[i];
        end
        model_reset();
        test_reset();
        test_fetch();
        test_store_load();
        test_priority();
        test_back_to_back();
        test_held_req();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
